// File: rtl/dds_sweep_pkg.sv
// dds_sweep_pkg: shared types for the DDS frequency-sweep scheduler.
//   sweep_mode_t  : sweep shape programmed with each config word
//   sweep_state_t : controller state
package dds_sweep_pkg;

  typedef enum logic [1:0] {
    SINGLE   = 2'd0,
    REPEAT   = 2'd1,
    TRIANGLE = 2'd2
  } sweep_mode_t;

  typedef enum logic [1:0] {
    IDLE,
    LOAD,
    RUN
  } sweep_state_t;

endpackage

// File: rtl/dds_sweep_step.sv
// dds_sweep_step: combinational next-value unit for the sweep scheduler.
//   cur      : current phase increment
//   step     : step magnitude
//   endpoint : value the current leg is travelling towards
//   dir      : 1 = increasing, 0 = decreasing
//   next     : cur +/- step, clamped to endpoint (never wraps)
//   at_end   : cur already equals endpoint
module dds_sweep_step #(
  parameter int unsigned PH_NUM_ACC_WIDTH = 32
) (
  input  logic [PH_NUM_ACC_WIDTH-1:0] cur,
  input  logic [PH_NUM_ACC_WIDTH-1:0] step,
  input  logic [PH_NUM_ACC_WIDTH-1:0] endpoint,
  input  logic                        dir,
  output logic [PH_NUM_ACC_WIDTH-1:0] next,
  output logic                        at_end
);

  localparam int unsigned W = PH_NUM_ACC_WIDTH;

  logic [W:0] sum;
  logic [W:0] diff;

  // One extra bit catches carry/borrow so an overshoot clamps instead of wrapping.
  always_comb begin
    sum    = {1'b0, cur} + {1'b0, step};
    diff   = {1'b0, cur} - {1'b0, step};
    at_end = (cur == endpoint);
    if (dir) begin
      next = (sum >= {1'b0, endpoint}) ? endpoint : sum[W-1:0];
    end else begin
      next = (diff[W] || (diff[W-1:0] <= endpoint)) ? endpoint : diff[W-1:0];
    end
  end

endmodule

// File: rtl/dds_sweep_ctrl.sv
// dds_sweep_ctrl: frequency-sweep scheduler driving dds_top.phase_inc.
//   clk, rst           : clock, synchronous active-high reset
//   ce                 : clock enable, nothing advances while low
//   cfg_valid/ready    : config handshake (ready only in IDLE with ce)
//   cfg_start_inc/stop : sweep endpoints, cfg_step magnitude
//   cfg_dwell          : each value held cfg_dwell+1 ce-cycles
//   cfg_mode           : 0 single, 1 repeat, 2 triangle, 3 single
//   start, abort       : begin / terminate a sweep
//   phase_inc          : registered phase increment to the DDS
//   dds_rst            : one-cycle accumulator reset at sweep start
//   busy, done         : sweep active / single sweep finished pulse
module dds_sweep_ctrl
  import dds_sweep_pkg::*;
#(
  parameter int unsigned PH_NUM_ACC_WIDTH = 32,
  parameter int unsigned DWELL_WIDTH      = 16
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        ce,
  input  logic                        cfg_valid,
  output logic                        cfg_ready,
  input  logic [PH_NUM_ACC_WIDTH-1:0] cfg_start_inc,
  input  logic [PH_NUM_ACC_WIDTH-1:0] cfg_stop_inc,
  input  logic [PH_NUM_ACC_WIDTH-1:0] cfg_step,
  input  logic [DWELL_WIDTH-1:0]      cfg_dwell,
  input  logic [1:0]                  cfg_mode,
  input  logic                        start,
  input  logic                        abort,
  output logic [PH_NUM_ACC_WIDTH-1:0] phase_inc,
  output logic                        dds_rst,
  output logic                        busy,
  output logic                        done
);

  localparam int unsigned W = PH_NUM_ACC_WIDTH;

  sweep_state_t     state, state_n;
  logic [W-1:0]     phase_n;
  logic             dds_rst_n, done_n;
  logic [DWELL_WIDTH-1:0] cnt, cnt_n;
  logic             dir_cur, dir_n;
  logic [W-1:0]     sh_start, sh_stop, sh_step;
  logic [W-1:0]     sh_start_n, sh_stop_n, sh_step_n;
  logic [DWELL_WIDTH-1:0] sh_dwell, sh_dwell_n;
  sweep_mode_t      sh_mode, sh_mode_n, cap_mode;
  logic             sh_dir, sh_dir_n, cap_dir;
  logic             cfg_loaded, loaded_n;
  logic             cfg_xfer;

  logic [W-1:0]     fwd_end, rev_end, fwd_next, rev_next;
  logic             fwd_at_end, rev_at_end_unused, at_end;

  assign cfg_ready = (state == IDLE) && ce;
  assign cfg_xfer  = cfg_valid && cfg_ready;
  assign busy      = (state != IDLE);
  assign cap_dir   = (cfg_stop_inc >= cfg_start_inc);

  always_comb begin
    unique case (cfg_mode)
      2'd1:    cap_mode = REPEAT;
      2'd2:    cap_mode = TRIANGLE;
      default: cap_mode = SINGLE;
    endcase
  end

  // The leg target is stop while travelling in the configured direction and
  // start on the return leg of a triangle.
  assign fwd_end = (dir_cur == sh_dir) ? sh_stop : sh_start;
  assign rev_end = (dir_cur == sh_dir) ? sh_start : sh_stop;

  dds_sweep_step #(.PH_NUM_ACC_WIDTH(W)) u_fwd (
    .cur(phase_inc), .step(sh_step), .endpoint(fwd_end), .dir(dir_cur),
    .next(fwd_next), .at_end(fwd_at_end)
  );

  dds_sweep_step #(.PH_NUM_ACC_WIDTH(W)) u_rev (
    .cur(phase_inc), .step(sh_step), .endpoint(rev_end), .dir(~dir_cur),
    .next(rev_next), .at_end(rev_at_end_unused)
  );

  // A zero step can never reach stop, so it is treated as already there.
  assign at_end = fwd_at_end || (sh_step == '0);

  always_comb begin
    state_n    = state;
    phase_n    = phase_inc;
    dds_rst_n  = 1'b0;
    done_n     = 1'b0;
    cnt_n      = cnt;
    dir_n      = dir_cur;
    sh_start_n = sh_start;
    sh_stop_n  = sh_stop;
    sh_step_n  = sh_step;
    sh_dwell_n = sh_dwell;
    sh_mode_n  = sh_mode;
    sh_dir_n   = sh_dir;
    loaded_n   = cfg_loaded;
    unique case (state)
      IDLE: begin
        if (cfg_xfer) begin
          sh_start_n = cfg_start_inc;
          sh_stop_n  = cfg_stop_inc;
          sh_step_n  = cfg_step;
          sh_dwell_n = cfg_dwell;
          sh_mode_n  = cap_mode;
          sh_dir_n   = cap_dir;
          loaded_n   = 1'b1;
        end
        if (start && (cfg_loaded || cfg_xfer)) begin
          state_n   = LOAD;
          dds_rst_n = 1'b1;
          phase_n   = cfg_xfer ? cfg_start_inc : sh_start;
          cnt_n     = cfg_xfer ? cfg_dwell : sh_dwell;
          dir_n     = cfg_xfer ? cap_dir : sh_dir;
        end
      end
      LOAD, RUN: begin
        if (abort) begin
          state_n = IDLE;
          phase_n = '0;
        end else begin
          // LOAD counts as the first dwell cycle of the start value.
          if (state == LOAD) state_n = RUN;
          if (cnt != '0) begin
            cnt_n = cnt - 1'b1;
          end else if (!at_end) begin
            phase_n = fwd_next;
            cnt_n   = sh_dwell;
          end else begin
            unique case (sh_mode)
              TRIANGLE: begin
                phase_n = rev_next;
                dir_n   = ~dir_cur;
                cnt_n   = sh_dwell;
              end
              REPEAT: begin
                phase_n = sh_start;
                dir_n   = sh_dir;
                cnt_n   = sh_dwell;
              end
              default: begin
                state_n = IDLE;
                done_n  = 1'b1;
              end
            endcase
          end
        end
      end
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      phase_inc  <= '0;
      dds_rst    <= 1'b0;
      done       <= 1'b0;
      cnt        <= '0;
      dir_cur    <= 1'b0;
      sh_start   <= '0;
      sh_stop    <= '0;
      sh_step    <= '0;
      sh_dwell   <= '0;
      sh_mode    <= SINGLE;
      sh_dir     <= 1'b0;
      cfg_loaded <= 1'b0;
    end else if (ce) begin
      state      <= state_n;
      phase_inc  <= phase_n;
      dds_rst    <= dds_rst_n;
      done       <= done_n;
      cnt        <= cnt_n;
      dir_cur    <= dir_n;
      sh_start   <= sh_start_n;
      sh_stop    <= sh_stop_n;
      sh_step    <= sh_step_n;
      sh_dwell   <= sh_dwell_n;
      sh_mode    <= sh_mode_n;
      sh_dir     <= sh_dir_n;
      cfg_loaded <= loaded_n;
    end
  end

endmodule

// File: tb/tb_dds_sweep_ctrl.sv
// tb_dds_sweep_ctrl: directed self-checking bench for dds_sweep_ctrl.
module tb_dds_sweep_ctrl;

  localparam int W  = 32;
  localparam int DW = 16;

  logic          clk = 1'b0;
  logic          rst, ce, cfg_valid, cfg_ready, start, abort;
  logic [W-1:0]  cfg_start_inc, cfg_stop_inc, cfg_step, phase_inc;
  logic [DW-1:0] cfg_dwell;
  logic [1:0]    cfg_mode;
  logic          dds_rst, busy, done;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  dds_sweep_ctrl #(.PH_NUM_ACC_WIDTH(W), .DWELL_WIDTH(DW)) dut (
    .clk(clk), .rst(rst), .ce(ce),
    .cfg_valid(cfg_valid), .cfg_ready(cfg_ready),
    .cfg_start_inc(cfg_start_inc), .cfg_stop_inc(cfg_stop_inc),
    .cfg_step(cfg_step), .cfg_dwell(cfg_dwell), .cfg_mode(cfg_mode),
    .start(start), .abort(abort),
    .phase_inc(phase_inc), .dds_rst(dds_rst), .busy(busy), .done(done)
  );

  // Config + start in the same cycle; returns at the negedge of the LOAD cycle.
  task automatic kick(input logic [W-1:0] s, input logic [W-1:0] p,
                      input logic [W-1:0] st, input logic [DW-1:0] d,
                      input logic [1:0] m);
    @(negedge clk);
    cfg_start_inc = s; cfg_stop_inc = p; cfg_step = st;
    cfg_dwell = d; cfg_mode = m; cfg_valid = 1'b1; start = 1'b1;
    @(negedge clk);
    cfg_valid = 1'b0; start = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1; ce = 1'b1; cfg_valid = 1'b0; start = 1'b0; abort = 1'b0;
    cfg_start_inc = '0; cfg_stop_inc = '0; cfg_step = '0; cfg_dwell = '0; cfg_mode = '0;
    repeat (2) @(negedge clk);
    checks++;
    if ({phase_inc, dds_rst, busy, done, cfg_ready} !== {32'd0, 1'b0, 1'b0, 1'b0, 1'b1}) begin
      errors++;
      $display("FAIL reset: phase=%0h rst=%b busy=%b done=%b ready=%b expected 0 0 0 0 1",
               phase_inc, dds_rst, busy, done, cfg_ready);
    end
    rst = 1'b0; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    checks++;
    if (busy !== 1'b0) begin
      errors++; $display("FAIL reset_start_no_cfg: busy=%b expected 0", busy);
    end
  endtask

  task automatic test_single_up();
    logic [W-1:0] e [8];
    e = '{1000, 1000, 1100, 1100, 1200, 1200, 1300, 1300};
    kick(1000, 1300, 100, 1, 0);
    for (int i = 0; i < 8; i++) begin
      if (i > 0) @(negedge clk);
      checks++;
      if (phase_inc !== e[i] || dds_rst !== (i == 0) || busy !== 1'b1 || done !== 1'b0) begin
        errors++;
        $display("FAIL single_up[%0d]: phase=%0d rst=%b busy=%b done=%b expected %0d %b 1 0",
                 i, phase_inc, dds_rst, busy, done, e[i], (i == 0));
      end
    end
    @(negedge clk);
    checks++;
    if (done !== 1'b1 || busy !== 1'b0 || phase_inc !== 32'd1300) begin
      errors++;
      $display("FAIL single_up_done: done=%b busy=%b phase=%0d expected 1 0 1300", done, busy, phase_inc);
    end
    @(negedge clk);
    checks++;
    if (done !== 1'b0 || phase_inc !== 32'd1300) begin
      errors++;
      $display("FAIL single_up_after: done=%b phase=%0d expected 0 1300", done, phase_inc);
    end
  endtask

  task automatic test_clamp_down();
    logic [W-1:0] e [2][4];
    e[0] = '{1000, 1100, 1200, 1250};
    e[1] = '{1300, 1200, 1100, 1000};
    for (int k = 0; k < 2; k++) begin
      if (k == 0) kick(1000, 1250, 100, 0, 0);
      else        kick(1300, 1000, 100, 0, 0);
      for (int i = 0; i < 4; i++) begin
        if (i > 0) @(negedge clk);
        checks++;
        if (phase_inc !== e[k][i] || done !== 1'b0) begin
          errors++;
          $display("FAIL clamp_down[%0d][%0d]: phase=%0d done=%b expected %0d 0", k, i, phase_inc, done, e[k][i]);
        end
      end
      @(negedge clk);
      checks++;
      if (done !== 1'b1 || phase_inc !== e[k][3]) begin
        errors++;
        $display("FAIL clamp_down_done[%0d]: done=%b phase=%0d expected 1 %0d", k, done, phase_inc, e[k][3]);
      end
    end
  endtask

  task automatic test_no_wrap();
    logic [W-1:0] e [3];
    e = '{32'hFFFFFF00, 32'hFFFFFF80, 32'hFFFFFFFF};
    kick(32'hFFFFFF00, 32'hFFFFFFFF, 32'h80, 0, 0);
    for (int i = 0; i < 3; i++) begin
      if (i > 0) @(negedge clk);
      checks++;
      if (phase_inc !== e[i]) begin
        errors++; $display("FAIL no_wrap[%0d]: phase=%0h expected %0h", i, phase_inc, e[i]);
      end
    end
    @(negedge clk);
    checks++;
    if (done !== 1'b1 || phase_inc !== 32'hFFFFFFFF) begin
      errors++; $display("FAIL no_wrap_done: done=%b phase=%0h expected 1 ffffffff", done, phase_inc);
    end
  endtask

  task automatic test_triangle_repeat();
    logic [W-1:0] t [9];
    logic [W-1:0] r [7];
    t = '{0, 100, 200, 100, 0, 100, 200, 100, 0};
    r = '{0, 100, 200, 0, 100, 200, 0};
    kick(0, 200, 100, 0, 2);
    for (int i = 0; i < 9; i++) begin
      if (i > 0) @(negedge clk);
      checks++;
      if (phase_inc !== t[i] || done !== 1'b0 || dds_rst !== (i == 0)) begin
        errors++;
        $display("FAIL triangle[%0d]: phase=%0d done=%b rst=%b expected %0d 0 %b", i, phase_inc, done, dds_rst, t[i], (i == 0));
      end
    end
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    kick(0, 200, 100, 0, 1);
    for (int i = 0; i < 7; i++) begin
      if (i > 0) @(negedge clk);
      checks++;
      if (phase_inc !== r[i] || done !== 1'b0 || dds_rst !== (i == 0)) begin
        errors++;
        $display("FAIL repeat[%0d]: phase=%0d done=%b rst=%b expected %0d 0 %b", i, phase_inc, done, dds_rst, r[i], (i == 0));
      end
    end
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    checks++;
    if (busy !== 1'b0 || phase_inc !== 32'd0) begin
      errors++; $display("FAIL repeat_abort: busy=%b phase=%0d expected 0 0", busy, phase_inc);
    end
  endtask

  task automatic test_boundaries();
    // step 0: start value held one dwell, then done
    kick(500, 900, 0, 1, 0);
    for (int i = 0; i < 2; i++) begin
      if (i > 0) @(negedge clk);
      checks++;
      if (phase_inc !== 32'd500 || done !== 1'b0) begin
        errors++; $display("FAIL step_zero[%0d]: phase=%0d done=%b expected 500 0", i, phase_inc, done);
      end
    end
    @(negedge clk);
    checks++;
    if (done !== 1'b1 || phase_inc !== 32'd500) begin
      errors++; $display("FAIL step_zero_done: done=%b phase=%0d expected 1 500", done, phase_inc);
    end
    // start == stop: one value for dwell+1 cycles
    kick(700, 700, 50, 2, 0);
    for (int i = 0; i < 3; i++) begin
      if (i > 0) @(negedge clk);
      checks++;
      if (phase_inc !== 32'd700 || done !== 1'b0) begin
        errors++; $display("FAIL start_eq_stop[%0d]: phase=%0d done=%b expected 700 0", i, phase_inc, done);
      end
    end
    @(negedge clk);
    checks++;
    if (done !== 1'b1) begin
      errors++; $display("FAIL start_eq_stop_done: done=%b expected 1", done);
    end
  endtask

  task automatic test_abort();
    kick(1000, 2000, 100, 0, 0);
    @(negedge clk);
    @(negedge clk);
    checks++;
    if (phase_inc !== 32'd1200) begin
      errors++; $display("FAIL abort_pre: phase=%0d expected 1200", phase_inc);
    end
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    checks++;
    if ({phase_inc, busy, done, dds_rst, cfg_ready} !== {32'd0, 1'b0, 1'b0, 1'b0, 1'b1}) begin
      errors++;
      $display("FAIL abort: phase=%0d busy=%b done=%b rst=%b ready=%b expected 0 0 0 0 1",
               phase_inc, busy, done, dds_rst, cfg_ready);
    end
    @(negedge clk);
    checks++;
    if (done !== 1'b0 || busy !== 1'b0) begin
      errors++; $display("FAIL abort_after: done=%b busy=%b expected 0 0", done, busy);
    end
  endtask

  task automatic test_rst_mid();
    kick(1000, 2000, 100, 0, 0);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    checks++;
    if ({phase_inc, busy, done, dds_rst} !== {32'd0, 1'b0, 1'b0, 1'b0}) begin
      errors++;
      $display("FAIL rst_mid: phase=%0d busy=%b done=%b rst=%b expected 0 0 0 0", phase_inc, busy, done, dds_rst);
    end
    start = 1'b1;
    @(negedge clk);
    @(negedge clk);
    start = 1'b0;
    checks++;
    if (busy !== 1'b0 || dds_rst !== 1'b0) begin
      errors++; $display("FAIL rst_mid_start: busy=%b rst=%b expected 0 0", busy, dds_rst);
    end
  endtask

  task automatic test_ce_toggle();
    logic [W-1:0] exp_v;
    kick(1000, 1200, 100, 1, 0);
    for (int i = 0; i < 12; i++) begin
      if (i > 0) @(negedge clk);
      exp_v = 32'd1000 + 32'd100 * W'(i / 4);
      checks++;
      if (phase_inc !== exp_v || done !== 1'b0) begin
        errors++; $display("FAIL ce_toggle[%0d]: phase=%0d done=%b expected %0d 0", i, phase_inc, done, exp_v);
      end
      ce = (i % 2 == 1);
    end
    @(negedge clk);
    checks++;
    if (done !== 1'b1 || busy !== 1'b0 || phase_inc !== 32'd1200) begin
      errors++; $display("FAIL ce_toggle_done: done=%b busy=%b phase=%0d expected 1 0 1200", done, busy, phase_inc);
    end
    ce = 1'b1;
    @(negedge clk);
    ce = 1'b0; start = 1'b1;
    #1;
    checks++;
    if (cfg_ready !== 1'b0) begin
      errors++; $display("FAIL ce_low_ready: ready=%b expected 0", cfg_ready);
    end
    @(negedge clk);
    @(negedge clk);
    start = 1'b0; ce = 1'b1;
    checks++;
    if (busy !== 1'b0 || dds_rst !== 1'b0) begin
      errors++; $display("FAIL ce_low_start: busy=%b rst=%b expected 0 0", busy, dds_rst);
    end
    @(negedge clk);
    checks++;
    if (busy !== 1'b0) begin
      errors++; $display("FAIL ce_low_start_after: busy=%b expected 0", busy);
    end
  endtask

  initial begin
    test_reset();
    test_single_up();
    test_clamp_down();
    test_no_wrap();
    test_triangle_repeat();
    test_boundaries();
    test_abort();
    test_rst_mid();
    test_ce_toggle();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
